// File: rtl/decoder_pipe.sv
// Instruction decoder with a small output FIFO between fetch and execute.
// Decodes 16-bit instructions into a control bundle tagged with PC; supports halt-on-RET and flush.
module decoder_pipe #(
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned PC_W       = 8,
    parameter int unsigned IMM_W      = 8,
    parameter bit          IMM_SIGNED = 1'b0,
    parameter bit          EXT_OPS    = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instruction,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  decoded_pc,
    output logic [3:0]       decoded_rd_address,
    output logic [3:0]       decoded_rs_address,
    output logic [3:0]       decoded_rt_address,
    output logic [2:0]       decoded_nzp,
    output logic [IMM_W-1:0] decoded_immediate,
    output logic             decoded_reg_write_enable,
    output logic             decoded_mem_read_enable,
    output logic             decoded_mem_write_enable,
    output logic             decoded_nzp_write_enable,
    output logic [1:0]       decoded_reg_input_mux,
    output logic [2:0]       decoded_alu_op,
    output logic             decoded_alu_output_mux,
    output logic             decoded_pc_mux,
    output logic             decoded_ret,
    output logic             decoded_illegal,
    output logic             halted
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [3:0]       rd;
        logic [3:0]       rs;
        logic [3:0]       rt;
        logic [2:0]       nzp;
        logic [IMM_W-1:0] imm;
        logic             reg_we;
        logic             mem_re;
        logic             mem_we;
        logic             nzp_we;
        logic [1:0]       reg_input_mux;
        logic [2:0]       alu_op;
        logic             alu_output_mux;
        logic             pc_mux;
        logic             ret;
        logic             illegal;
    } bundle_t;

    bundle_t          dec;
    bundle_t          head;
    bundle_t          mem [BUF_DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic             halted_q, halted_d;
    logic             push, pop;

    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        dec.rd  = in_instruction[11:8];
        dec.rs  = in_instruction[7:4];
        dec.rt  = in_instruction[3:0];
        dec.nzp = in_instruction[11:9];
        if (IMM_SIGNED) dec.imm = IMM_W'($signed(in_instruction[7:0]));
        else            dec.imm = IMM_W'(in_instruction[7:0]);
        case (in_instruction[15:12])
            4'b0000: ;
            4'b0001: dec.pc_mux = 1'b1;
            4'b0010: begin
                dec.alu_output_mux = 1'b1;
                dec.nzp_we         = 1'b1;
            end
            4'b0011, 4'b0100, 4'b0101, 4'b0110: begin
                dec.reg_we = 1'b1;
                dec.alu_op = 3'(in_instruction[15:12] - 4'd3);
            end
            4'b0111: begin
                dec.reg_we        = 1'b1;
                dec.reg_input_mux = 2'b01;
                dec.mem_re        = 1'b1;
            end
            4'b1000: dec.mem_we = 1'b1;
            4'b1001: begin
                dec.reg_we        = 1'b1;
                dec.reg_input_mux = 2'b10;
            end
            4'b1010, 4'b1011: begin
                if (EXT_OPS) begin
                    dec.reg_we = 1'b1;
                    dec.alu_op = {2'b10, in_instruction[12]};
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            4'b1111: dec.ret = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
    end

    assign out_valid = (count_q != '0);
    assign in_ready  = reset_n && (count_q < FULL_CNT) && !halted_q && !flush;
    assign push      = in_valid && in_ready;
    // A pop coinciding with flush is void; flush already empties the buffer.
    assign pop       = out_valid && out_ready && !flush;
    assign halted    = halted_q;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        halted_d = halted_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            halted_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
                if (dec.ret) halted_d = 1'b1;
            end
            if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            halted_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= dec;
    end

    // Gating on out_valid zeroes every output when empty, including during async reset.
    assign head = out_valid ? mem[rd_ptr_q] : '0;

    assign decoded_pc               = head.pc;
    assign decoded_rd_address       = head.rd;
    assign decoded_rs_address       = head.rs;
    assign decoded_rt_address       = head.rt;
    assign decoded_nzp              = head.nzp;
    assign decoded_immediate        = head.imm;
    assign decoded_reg_write_enable = head.reg_we;
    assign decoded_mem_read_enable  = head.mem_re;
    assign decoded_mem_write_enable = head.mem_we;
    assign decoded_nzp_write_enable = head.nzp_we;
    assign decoded_reg_input_mux    = head.reg_input_mux;
    assign decoded_alu_op           = head.alu_op;
    assign decoded_alu_output_mux   = head.alu_output_mux;
    assign decoded_pc_mux           = head.pc_mux;
    assign decoded_ret              = head.ret;
    assign decoded_illegal          = head.illegal;

endmodule
